// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector of a combinational
// DUT, holds each one for HOLD_CYCLES cycles, then compares the response to a
// parameter table. Reports mismatch count, first failing vector and pass/done.
module tt_sweep_checker #(
    parameter int unsigned N_IN        = 3,
    parameter int unsigned N_OUT       = 1,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_OUT-1:0]  dut_resp,
    output logic [N_IN-1:0]   vec_out,
    output logic              sample_strobe,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam int unsigned N_VEC  = 2 ** N_IN;
    localparam int unsigned CNT_W  = N_IN + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(N_VEC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [N_IN-1:0]   vec_nxt;
    logic              strobe_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              pass_nxt;
    logic [CNT_W-1:0]  err_nxt;
    logic              ffv_nxt;
    logic [N_IN-1:0]   ffvec_nxt;

    logic [N_OUT-1:0]  exp_table [N_VEC];
    logic [N_OUT-1:0]  exp_resp;
    logic              mismatch;
    logic              last_vec;

    // Unpack the flat expected-response parameter into a per-vector table
    for (genvar gv = 0; gv < N_VEC; gv++) begin : g_exp
        assign exp_table[gv] = EXPECTED[gv*N_OUT +: N_OUT];
    end

    assign exp_resp = exp_table[vec_out];
    assign mismatch = (dut_resp != exp_resp);
    assign last_vec = &vec_out;

    // Next-state and next-output logic for the sweep sequencer
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        vec_nxt      = vec_out;
        strobe_nxt   = 1'b0;
        busy_nxt     = busy;
        done_nxt     = done;
        pass_nxt     = pass;
        err_nxt      = err_count;
        ffv_nxt      = first_fail_valid;
        ffvec_nxt    = first_fail_vec;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt    = S_DRIVE;
                    hold_cnt_nxt = HOLD_RELOAD;
                    vec_nxt      = '0;
                    err_nxt      = '0;
                    ffv_nxt      = 1'b0;
                    ffvec_nxt    = '0;
                    done_nxt     = 1'b0;
                    pass_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end

            S_DRIVE: begin
                // The strobe is registered, so raise it on the edge entering SAMPLE
                if (hold_cnt == '0) begin
                    state_nxt  = S_SAMPLE;
                    strobe_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    // Cannot exceed N_VEC in practice; the guard keeps it from ever wrapping
                    if (err_count != CNT_MAX) begin
                        err_nxt = err_count + CNT_W'(1);
                    end
                    if (!first_fail_valid) begin
                        ffv_nxt   = 1'b1;
                        ffvec_nxt = vec_out;
                    end
                end

                if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = !mismatch && (err_count == '0);
                end else begin
                    state_nxt    = S_DRIVE;
                    vec_nxt      = vec_out + N_IN'(1);
                    hold_cnt_nxt = HOLD_RELOAD;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep and clears results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            hold_cnt         <= '0;
            vec_out          <= '0;
            sample_strobe    <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            state            <= state_nxt;
            hold_cnt         <= hold_cnt_nxt;
            vec_out          <= vec_nxt;
            sample_strobe    <= strobe_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            pass             <= pass_nxt;
            err_count        <= err_nxt;
            first_fail_valid <= ffv_nxt;
            first_fail_vec   <= ffvec_nxt;
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: three checker instances (full sweep,
// stop-on-fail, wide/long-hold) each facing a table-driven fake DUT.
module tb_tt_sweep_checker;

    localparam logic [7:0]  EXP0 = 8'b1001_0110;
    localparam logic [31:0] EXP2 = 32'hC3A5_1E7B;

    typedef struct {
        int inst;
        int vec;
    } strobe_t;

    typedef struct {
        int inst;
        int err;
        int ffv;
        int ffvec;
        int pass;
        int vec;
        int cycles;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1, start2;

    logic       resp0, resp1;
    logic [1:0] resp2;
    logic [2:0] vec0, vec1, ffvec0, ffvec1;
    logic [3:0] vec2, ffvec2;
    logic [3:0] err0, err1;
    logic [4:0] err2;
    logic strobe0, busy0, done0, pass0, ffv0;
    logic strobe1, busy1, done1, pass1, ffv1;
    logic strobe2, busy2, done2, pass2, ffv2;

    // fake DUT response tables
    logic [1:0] rt0 [8];
    logic [1:0] rt1 [8];
    logic [1:0] rt2 [16];

    assign resp0 = rt0[vec0][0];
    assign resp1 = rt1[vec1][0];
    assign resp2 = rt2[vec2];

    int w_vec [3], w_strobe [3], w_busy [3], w_done [3];
    int w_pass [3], w_err [3], w_ffv [3], w_ffvec [3];

    strobe_t sq[$];
    done_t   dq[$];
    int      start_cyc [3];
    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    logic [2:0] done_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_sweep_checker #(.N_IN(3), .N_OUT(1), .HOLD_CYCLES(1), .EXPECTED(EXP0), .STOP_ON_FAIL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_resp(resp0), .vec_out(vec0),
        .sample_strobe(strobe0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

    tt_sweep_checker #(.N_IN(3), .N_OUT(1), .HOLD_CYCLES(1), .EXPECTED(EXP0), .STOP_ON_FAIL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_resp(resp1), .vec_out(vec1),
        .sample_strobe(strobe1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

    tt_sweep_checker #(.N_IN(4), .N_OUT(2), .HOLD_CYCLES(3), .EXPECTED(EXP2), .STOP_ON_FAIL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_resp(resp2), .vec_out(vec2),
        .sample_strobe(strobe2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2));

    // widened views so one monitor loop covers all instances
    always_comb begin
        w_vec[0] = int'(vec0);   w_vec[1] = int'(vec1);   w_vec[2] = int'(vec2);
        w_strobe[0] = int'(strobe0); w_strobe[1] = int'(strobe1); w_strobe[2] = int'(strobe2);
        w_busy[0] = int'(busy0); w_busy[1] = int'(busy1); w_busy[2] = int'(busy2);
        w_done[0] = int'(done0); w_done[1] = int'(done1); w_done[2] = int'(done2);
        w_pass[0] = int'(pass0); w_pass[1] = int'(pass1); w_pass[2] = int'(pass2);
        w_err[0] = int'(err0);   w_err[1] = int'(err1);   w_err[2] = int'(err2);
        w_ffv[0] = int'(ffv0);   w_ffv[1] = int'(ffv1);   w_ffv[2] = int'(ffv2);
        w_ffvec[0] = int'(ffvec0); w_ffvec[1] = int'(ffvec1); w_ffvec[2] = int'(ffvec2);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_of(input int k, input int v);
        if (k == 2) return int'((EXP2 >> (2 * v)) & 32'd3);
        return int'((EXP0 >> v) & 8'd1);
    endfunction

    function automatic int resp_of(input int k, input int v);
        case (k)
            0:       return int'(rt0[v][0]);
            1:       return int'(rt1[v][0]);
            default: return int'(rt2[v]);
        endcase
    endfunction

    // Program instance k's fake DUT: good behaviour, corrupted on vectors in 'faults'
    task automatic set_resp(input int k, input logic [15:0] faults);
        int n;
        int good;
        logic [1:0] val;
        n = (k == 2) ? 16 : 8;
        for (int v = 0; v < n; v++) begin
            if (k == 2) good = exp_of(2, v);
            else        good = $countones(v) & 1;
            val = 2'(good);
            if (faults[v]) begin
                if (k == 2) val = val ^ 2'($urandom_range(1, 3));
                else        val = val ^ 2'b01;
            end
            case (k)
                0:       rt0[v] = val;
                1:       rt1[v] = val;
                default: rt2[v] = val;
            endcase
        end
    endtask

    // Reference: predict strobe order and final report for one sweep
    task automatic run_model(input int k);
        int n, h, err, ffv, ffvec, last;
        bit stop, mm;
        done_t d;
        strobe_t s;
        n = (k == 2) ? 16 : 8;
        h = (k == 2) ? 3 : 1;
        stop = (k == 1);
        err = 0; ffv = 0; ffvec = 0; last = n - 1;
        for (int v = 0; v < n; v++) begin
            s.inst = k; s.vec = v;
            sq.push_back(s);
            mm = (resp_of(k, v) != exp_of(k, v));
            if (mm) begin
                err++;
                if (ffv == 0) begin ffv = 1; ffvec = v; end
            end
            if (stop && mm) begin last = v; break; end
        end
        d.inst = k; d.err = err; d.ffv = ffv; d.ffvec = ffvec;
        d.pass = (err == 0) ? 1 : 0; d.vec = last; d.cycles = (last + 1) * (h + 1);
        dq.push_back(d);
    endtask

    task automatic set_start(input int k, input logic val);
        case (k)
            0:       start0 = val;
            1:       start1 = val;
            default: start2 = val;
        endcase
    endtask

    task automatic launch(input int k);
        run_model(k);
        @(negedge clk);
        set_start(k, 1'b1);
        @(negedge clk);
        start_cyc[k] = cyc;
        set_start(k, 1'b0);
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (w_done[k] == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (w_done[k] == 0) chk($sformatf("timeout_done_%0d", k), 0, 1);
        @(negedge clk);
    endtask

    // Monitor: pop expectations on every strobe and on each rising done
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst !== 1'b1) begin
                if (w_strobe[k] != 0) begin
                    if (sq.size() == 0 || sq[0].inst != k) begin
                        chk($sformatf("strobe_unexpected_%0d", k), w_vec[k], -1);
                    end else begin
                        strobe_t s;
                        s = sq.pop_front();
                        chk($sformatf("strobe_vec_%0d", k), w_vec[k], s.vec);
                        chk($sformatf("busy_in_sweep_%0d", k), w_busy[k], 1);
                    end
                end
                if (w_done[k] != 0 && !done_prev[k]) begin
                    if (dq.size() == 0 || dq[0].inst != k) begin
                        chk($sformatf("done_unexpected_%0d", k), 1, 0);
                    end else begin
                        done_t d;
                        int left;
                        d = dq.pop_front();
                        left = 0;
                        foreach (sq[i]) if (sq[i].inst == k) left++;
                        chk($sformatf("err_count_%0d", k), w_err[k], d.err);
                        chk($sformatf("first_fail_valid_%0d", k), w_ffv[k], d.ffv);
                        chk($sformatf("first_fail_vec_%0d", k), w_ffvec[k], d.ffvec);
                        chk($sformatf("pass_%0d", k), w_pass[k], d.pass);
                        chk($sformatf("vec_at_done_%0d", k), w_vec[k], d.vec);
                        chk($sformatf("busy_at_done_%0d", k), w_busy[k], 0);
                        chk($sformatf("done_latency_%0d", k), cyc - start_cyc[k], d.cycles);
                        chk($sformatf("strobes_missing_%0d", k), left, 0);
                    end
                end
            end
            done_prev[k] <= (w_done[k] != 0);
        end
    end

    initial begin
        int k, wait_n;
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        set_resp(0, '0); set_resp(1, '0); set_resp(2, '0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_vec_%0d", i), w_vec[i], 0);
            chk($sformatf("reset_done_%0d", i), w_done[i], 0);
            chk($sformatf("reset_busy_%0d", i), w_busy[i], 0);
            chk($sformatf("reset_err_%0d", i), w_err[i], 0);
        end
        rst = 1'b0;

        // clean XOR3 sweep, then vector 5 corrupted (restart straight from DONE)
        set_resp(0, '0);          launch(0); wait_done(0, 100);
        set_resp(0, 16'h0020);    launch(0); wait_done(0, 100);

        // stop-on-fail with faults at 2 and 6
        set_resp(1, 16'h0044);    launch(1); wait_done(1, 100);

        // wide outputs, 4-cycle hold, clean then faulted
        set_resp(2, '0);          launch(2); wait_done(2, 200);
        set_resp(2, 16'h8101);    launch(2); wait_done(2, 200);

        // start pulsed while busy must be ignored
        set_resp(0, 16'h0088);    launch(0);
        repeat (3) @(negedge clk);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        wait_done(0, 100);

        // asynchronous reset mid-sweep at vector 4
        set_resp(0, 16'h0003);    launch(0);
        wait_n = 0;
        while (w_vec[0] != 4 && wait_n < 100) begin @(negedge clk); wait_n++; end
        chk("reach_vec4", w_vec[0], 4);
        #2 rst = 1'b1;
        #1;
        chk("abort_vec", w_vec[0], 0);
        chk("abort_busy", w_busy[0], 0);
        chk("abort_done", w_done[0], 0);
        chk("abort_err", w_err[0], 0);
        chk("abort_ffv", w_ffv[0], 0);
        chk("abort_ffvec", w_ffvec[0], 0);
        chk("abort_pass", w_pass[0], 0);
        chk("abort_strobe", w_strobe[0], 0);
        sq.delete();
        dq.delete();
        @(negedge clk);
        rst = 1'b0;
        set_resp(0, 16'h0010);    launch(0); wait_done(0, 100);

        // randomized sweeps on random instances
        for (int r = 0; r < 15; r++) begin
            logic [15:0] f;
            k = $urandom_range(0, 2);
            f = '0;
            for (int v = 0; v < 16; v++) f[v] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) f = '0;
            set_resp(k, f);
            launch(k);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                set_start(k, 1'b1); @(negedge clk); set_start(k, 1'b0);
            end
            wait_done(k, 200);
        end

        chk("strobe_queue_empty", sq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
